irq_sequencer: RTL and testbench

Sequences interrupt entry and return for the next-PC unit. Captures three edge-triggered interrupt lines, arbitrates them by fixed priority, picks a safe instruction boundary in decode (never a branch delay slot), and then forces the next-PC op to IRQ with the winning vector number. It also holds EPC, blocks nesting while a handler runs, and leaves the handler state on `eret`. It sits beside the decode stage and drives the `int_num`/`epc` inputs of the next-PC logic plus an override of its op select.

---
 rtl/irq_sequencer.sv | 144 ++++++++++++++
 tb/tb_irq_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: interrupt entry/return sequencer that sits beside decode.
// Captures three edge-triggered request lines, arbitrates them by fixed
// priority (source 0 highest), waits for a decode slot that is not a branch
// delay slot, then overrides the next-PC op with IRQ and the winning vector.
// Also holds EPC and blocks nesting until the handler's eret is accepted.
module irq_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  irq_in,
    input  logic [2:0]  irq_en,
    input  logic        id_valid,
    input  logic        stall,
    input  logic [31:0] id_pc_4,
    input  logic        id_is_branch,
    input  logic        id_is_eret,
    output logic        irq_take,
    output logic [1:0]  int_num,
    output logic [31:0] epc,
    output logic        in_isr
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ISR  = 1'b1
    } state_e;

    // Value driven on int_num whenever no interrupt is being taken.
    localparam logic [1:0] INT_NONE = 2'h3;

    state_e      state_q, state_d;
    logic [2:0]  irq_q, irq_d;
    logic [2:0]  pend_q, pend_d;
    logic        prev_br_q, prev_br_d;
    logic [31:0] epc_q, epc_d;

    logic [2:0]  rise;
    logic [2:0]  elig;
    logic        acc;
    logic        win_any;
    logic [1:0]  win_num;
    logic [2:0]  win_onehot;

    // Request edge detection, eligibility and the decode-accept qualifier.
    always_comb begin
        rise = irq_in & ~irq_q;
        elig = pend_q & irq_en;
        acc  = id_valid & ~stall;
    end

    // Fixed-priority pick of the lowest-index eligible source.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned and no latch is inferred.
        win_any    = |elig;
        win_num    = INT_NONE;
        win_onehot = 3'b000;
        if (elig[0]) begin
            win_num    = 2'd0;
            win_onehot = 3'b001;
        end else if (elig[1]) begin
            win_num    = 2'd1;
            win_onehot = 3'b010;
        end else if (elig[2]) begin
            win_num    = 2'd2;
            win_onehot = 3'b100;
        end
    end

    // FSM next-state and the combinational take/vector outputs.
    always_comb begin
        state_d  = state_q;
        irq_take = 1'b0;
        int_num  = INT_NONE;
        unique case (state_q)
            ST_IDLE: begin
                // A stray eret in IDLE is neither taken over nor acted on.
                // Reset gates the take so nothing escapes during reset.
                if (!rst && win_any && acc && !prev_br_q && !id_is_eret) begin
                    irq_take = 1'b1;
                    int_num  = win_num;
                    state_d  = ST_ISR;
                end
            end
            ST_ISR: begin
                if (acc && id_is_eret) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the capture, pending, delay-slot and EPC registers.
    always_comb begin
        irq_d     = irq_in;
        pend_d    = pend_q;
        prev_br_d = prev_br_q;
        epc_d     = epc_q;

        // Clear the taken source first so a coincident new edge (set) wins.
        if (irq_take) begin
            pend_d = pend_d & ~win_onehot;
        end
        pend_d = pend_d | rise;

        // prev_br tracks whether the next accepted instruction is a delay slot.
        if (irq_take) begin
            prev_br_d = 1'b0;
        end else if (acc) begin
            prev_br_d = id_is_branch;
        end

        // The flushed decode instruction re-executes on return: EPC is its PC.
        if (irq_take) begin
            epc_d = id_pc_4 - 32'd4;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q   <= ST_IDLE;
            irq_q     <= 3'b000;
            pend_q    <= 3'b000;
            prev_br_q <= 1'b0;
            epc_q     <= 32'h0000_0000;
        end else begin
            state_q   <= state_d;
            irq_q     <= irq_d;
            pend_q    <= pend_d;
            prev_br_q <= prev_br_d;
            epc_q     <= epc_d;
        end
    end

    // Registered outputs straight from the flops.
    always_comb begin
        epc    = epc_q;
        in_isr = (state_q == ST_ISR);
    end

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed vectors with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled
// 1 unit later, well away from the next rising edge.
module tb_irq_sequencer;

    logic        clk;
    logic        rst;
    logic [2:0]  irq_in;
    logic [2:0]  irq_en;
    logic        id_valid;
    logic        stall;
    logic [31:0] id_pc_4;
    logic        id_is_branch;
    logic        id_is_eret;
    logic        irq_take;
    logic [1:0]  int_num;
    logic [31:0] epc;
    logic        in_isr;

    int n_checks = 0;
    int n_pass   = 0;

    irq_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .irq_in       (irq_in),
        .irq_en       (irq_en),
        .id_valid     (id_valid),
        .stall        (stall),
        .id_pc_4      (id_pc_4),
        .id_is_branch (id_is_branch),
        .id_is_eret   (id_is_eret),
        .irq_take     (irq_take),
        .int_num      (int_num),
        .epc          (epc),
        .in_isr       (in_isr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        irq_in       = 3'b000;
        irq_en       = 3'b111;
        id_valid     = 1'b0;
        stall        = 1'b0;
        id_pc_4      = 32'h0;
        id_is_branch = 1'b0;
        id_is_eret   = 1'b0;
        tick();
        tick();
        settle();
        check("rst_take",   32'(irq_take), 32'd0);
        check("rst_intnum", 32'(int_num),  32'd3);
        check("rst_epc",    epc,           32'h0);
        check("rst_in_isr", 32'(in_isr),   32'd0);
        rst = 1'b0;
        tick();

        // Single request on source 1.
        id_valid = 1'b1;
        id_pc_4  = 32'h1008;
        irq_in   = 3'b010;
        settle();
        check("s1_no_take_edge_cycle", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("s1_take",   32'(irq_take), 32'd1);
        check("s1_intnum", 32'(int_num),  32'd1);
        tick();
        check("s1_epc",    epc,          32'h1004);
        check("s1_in_isr", 32'(in_isr),  32'd1);
        check("s1_isr_no_take", 32'(irq_take), 32'd0);
        id_is_eret = 1'b1;
        irq_in     = 3'b000;
        tick();
        id_is_eret = 1'b0;
        settle();
        check("s1_ret_in_isr", 32'(in_isr),   32'd0);
        check("s1_ret_take",   32'(irq_take), 32'd0);

        // Priority: sources 0 and 2 rise together.
        irq_in  = 3'b101;
        id_pc_4 = 32'h3000;
        settle();
        check("pri_edge_no_take", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("pri_take0",   32'(irq_take), 32'd1);
        check("pri_intnum0", 32'(int_num),  32'd0);
        tick();
        check("pri_in_isr0", 32'(in_isr), 32'd1);
        check("pri_epc0",    epc,         32'h2ffc);
        id_is_eret = 1'b1;
        settle();
        check("pri_eret_no_take", 32'(irq_take), 32'd0);
        check("pri_eret_intnum",  32'(int_num),  32'd3);
        tick();
        id_is_eret = 1'b0;
        id_pc_4    = 32'h3100;
        settle();
        check("pri_ret_in_isr", 32'(in_isr),   32'd0);
        check("pri_take2",      32'(irq_take), 32'd1);
        check("pri_intnum2",    32'(int_num),  32'd2);
        tick();
        check("pri_in_isr2", 32'(in_isr), 32'd1);
        check("pri_epc2",    epc,         32'h30fc);
        id_is_eret = 1'b1;
        irq_in     = 3'b000;
        tick();
        id_is_eret = 1'b0;

        // Delay slot: request rises while a branch is in decode.
        id_is_branch = 1'b1;
        id_pc_4      = 32'h2008;
        irq_in       = 3'b100;
        settle();
        check("ds_branch_no_take", 32'(irq_take), 32'd0);
        tick();
        id_is_branch = 1'b0;
        id_pc_4      = 32'h200c;
        settle();
        check("ds_slot_no_take", 32'(irq_take), 32'd0);
        tick();
        id_pc_4 = 32'h2010;
        settle();
        check("ds_take",   32'(irq_take), 32'd1);
        check("ds_intnum", 32'(int_num),  32'd2);
        tick();
        check("ds_epc",    epc,         32'h200c);
        check("ds_in_isr", 32'(in_isr), 32'd1);
        id_is_eret = 1'b1;
        irq_in     = 3'b000;
        tick();
        id_is_eret = 1'b0;

        // Stall: pending request waits out three stalled cycles.
        id_valid = 1'b0;
        irq_in   = 3'b001;
        tick();
        stall    = 1'b1;
        id_valid = 1'b1;
        id_pc_4  = 32'h4008;
        for (int i = 0; i < 3; i++) begin
            settle();
            check($sformatf("stall_no_take_%0d", i), 32'(irq_take), 32'd0);
            tick();
        end
        stall = 1'b0;
        settle();
        check("stall_take",   32'(irq_take), 32'd1);
        check("stall_intnum", 32'(int_num),  32'd0);
        tick();
        check("stall_epc", epc, 32'h4004);
        id_is_eret = 1'b1;
        irq_in     = 3'b000;
        tick();
        id_is_eret = 1'b0;

        // Mask: source 0 pending but disabled, then re-enabled.
        irq_en  = 3'b110;
        irq_in  = 3'b001;
        id_pc_4 = 32'h5008;
        tick();
        settle();
        check("mask_no_take_a", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("mask_no_take_b", 32'(irq_take), 32'd0);
        irq_en = 3'b111;
        settle();
        check("mask_reen_take",   32'(irq_take), 32'd1);
        check("mask_reen_intnum", 32'(int_num),  32'd0);
        tick();
        check("mask_in_isr", 32'(in_isr), 32'd1);
        check("mask_epc",    epc,         32'h5004);

        // Nesting: a new edge during the handler is held until return.
        irq_in = 3'b000;
        tick();
        irq_in = 3'b001;
        settle();
        check("nest_no_take_a", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("nest_no_take_b", 32'(irq_take), 32'd0);
        check("nest_epc_held_a", epc, 32'h5004);
        tick();
        check("nest_epc_held_b", epc,         32'h5004);
        check("nest_in_isr",     32'(in_isr), 32'd1);
        id_is_eret = 1'b1;
        tick();
        id_is_eret = 1'b0;
        id_pc_4    = 32'h0000_0004;
        settle();
        check("nest_ret_in_isr", 32'(in_isr),   32'd0);
        check("nest_ret_take",   32'(irq_take), 32'd1);
        check("nest_ret_intnum", 32'(int_num),  32'd0);
        tick();
        check("nest_epc_wrap", epc,         32'h0);
        check("nest_in_isr2",  32'(in_isr), 32'd1);

        // Reset mid-handler with sources 1 and 2 pending.
        irq_in = 3'b000;
        tick();
        irq_in = 3'b110;
        tick();
        settle();
        check("rmid_isr_no_take", 32'(irq_take), 32'd0);
        rst = 1'b1;
        tick();
        settle();
        check("rmid_take",   32'(irq_take), 32'd0);
        check("rmid_intnum", 32'(int_num),  32'd3);
        check("rmid_epc",    epc,           32'h0);
        check("rmid_in_isr", 32'(in_isr),   32'd0);
        rst     = 1'b0;
        id_pc_4 = 32'h7008;
        settle();
        check("rmid_pend_cleared", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("rmid_recapture_take",   32'(irq_take), 32'd1);
        check("rmid_recapture_intnum", 32'(int_num),  32'd1);
        tick();
        check("rmid_recapture_epc", epc, 32'h7004);

        // Reset held while a take would otherwise fire (source 2 pending).
        id_is_eret = 1'b1;
        tick();
        id_is_eret = 1'b0;
        rst        = 1'b1;
        irq_in     = 3'b000;
        settle();
        check("rst_gates_take",   32'(irq_take), 32'd0);
        check("rst_gates_intnum", 32'(int_num),  32'd3);
        tick();
        rst = 1'b0;

        // Stray eret in IDLE: no take, no state change, EPC untouched.
        id_valid = 1'b0;
        irq_in   = 3'b001;
        tick();
        id_valid   = 1'b1;
        id_is_eret = 1'b1;
        settle();
        check("stray_no_take", 32'(irq_take), 32'd0);
        tick();
        settle();
        check("stray_in_isr", 32'(in_isr), 32'd0);
        check("stray_epc",    epc,         32'h0);
        id_is_eret = 1'b0;
        settle();
        check("stray_then_take", 32'(irq_take), 32'd1);
        check("stray_intnum",    32'(int_num),  32'd0);
        tick();
        check("stray_epc_after", epc,         32'h7004);
        check("stray_in_isr2",   32'(in_isr), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
